bpb_update_queue: RTL and testbench

- Buffers resolved-branch outcomes from the dual-issue execute/commit stage and drains them one per cycle into the branch prediction buffer's single write port (pc_commit / wen / destpc_commit).
- Sits directly upstream of the BPB update path; the consumer-side wrapper packs taken/target into the BPB result format.
- Absorbs bursts of two resolutions per cycle and coalesces repeated updates to the same PC.
- Updates are hints: overflow drops them and counts the drop. The pipeline never stalls on this block.

---
 rtl/bpb_update_queue.sv | 184 ++++++++++++++++++
 tb/tb_bpb_update_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpb_update_queue.sv
// Branch-outcome update queue feeding the BPB write port.
// Takes up to two resolved branches per cycle, coalesces updates to the PC
// already sitting at the tail, and drains one entry per cycle. Updates are
// hints, so a full queue drops them (and counts the drops) instead of stalling.
module bpb_update_queue #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int DROP_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [1:0]         in_valid,
  input  logic [1:0][31:0]   in_pc,
  input  logic [1:0]         in_taken,
  input  logic [1:0][31:0]   in_target,
  input  logic               out_stall,
  output logic               wen,
  output logic [31:0]        pc_commit,
  output logic               taken_commit,
  output logic [31:0]        target_commit,
  output logic [PTR_W:0]     count,
  output logic [DROP_W-1:0]  drop_cnt
);

  localparam logic [PTR_W:0] LP_ONE = (PTR_W+1)'(1);

  // Queue bookkeeping
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  logic [DROP_W-1:0] r_drop;

  // Per-entry read views gathered from the storage generate block
  logic [31:0] w_pc_arr     [DEPTH];
  logic        w_taken_arr  [DEPTH];
  logic [31:0] w_target_arr [DEPTH];

  // Pop / newest-entry view
  logic             w_wen;
  logic [PTR_W-1:0] w_newest_idx;
  logic             w_newest_ok;
  logic [PTR_W:0]   w_space;
  logic             w_has1;
  logic             w_has2;

  // Lane decisions
  logic             w_v0;
  logic             w_v1;
  logic             w_merge0;
  logic             w_alloc0;
  logic             w_drop0;
  logic             w_merge1;
  logic             w_alloc1;
  logic             w_drop1;
  logic [PTR_W-1:0] w_slot1;
  logic [PTR_W-1:0] w_merge1_idx;

  // Drop counter next value
  logic [DROP_W:0]   w_drop_sum;
  logic [DROP_W-1:0] w_drop_next;

  // The BPB write is driven straight from registered occupancy, so a reset
  // clearing r_count drops wen without waiting for a clock.
  assign w_wen        = (r_count != '0) & ~out_stall;
  assign w_newest_idx = r_tail - PTR_W'(1);
  // The newest entry may only absorb a merge if it is not leaving this cycle.
  assign w_newest_ok  = (r_count != '0) & ~((r_count == LP_ONE) & w_wen);
  // Free space deliberately ignores the pop in flight.
  assign w_space      = (PTR_W+1)'(DEPTH) - r_count;
  assign w_has1       = (w_space != '0);
  assign w_has2       = (w_space > LP_ONE);

  // Lane 0 loses to lane 1 when both carry the same PC: lane 1 is younger.
  assign w_v0 = in_valid[0] & ~(in_valid[1] & (in_pc[0] == in_pc[1]));
  assign w_v1 = in_valid[1];

  // Per-lane merge / allocate / drop decisions, lane 0 first
  always_comb begin
    w_merge0     = 1'b0;
    w_alloc0     = 1'b0;
    w_drop0      = 1'b0;
    w_merge1     = 1'b0;
    w_alloc1     = 1'b0;
    w_drop1      = 1'b0;
    w_slot1      = r_tail;
    w_merge1_idx = w_newest_idx;

    if (w_v0) begin
      if (w_newest_ok && (in_pc[0] == w_pc_arr[w_newest_idx])) begin
        w_merge0 = 1'b1;
      end else if (w_has1) begin
        w_alloc0 = 1'b1;
      end else begin
        w_drop0 = 1'b1;
      end
    end

    if (w_alloc0) begin
      // Lane 0's fresh slot is now the newest entry lane 1 can merge into.
      w_slot1      = r_tail + PTR_W'(1);
      w_merge1_idx = r_tail;
    end

    if (w_v1) begin
      if (w_alloc0 ? (in_pc[1] == in_pc[0])
                   : (w_newest_ok && (in_pc[1] == w_pc_arr[w_newest_idx]))) begin
        w_merge1 = 1'b1;
      end else if (!w_drop0 && (w_alloc0 ? w_has2 : w_has1)) begin
        w_alloc1 = 1'b1;
      end else begin
        w_drop1 = 1'b1;
      end
    end
  end

  // Saturating add of this cycle's drops
  always_comb begin
    w_drop_sum  = {1'b0, r_drop} + (DROP_W+1)'(w_drop0) + (DROP_W+1)'(w_drop1);
    w_drop_next = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
  end

  // Pointer, occupancy and drop-counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_wen);
      r_tail  <= r_tail + PTR_W'(w_alloc0) + PTR_W'(w_alloc1);
      r_count <= r_count + (PTR_W+1)'(w_alloc0) + (PTR_W+1)'(w_alloc1)
                 - (PTR_W+1)'(w_wen);
      r_drop  <= w_drop_next;
    end
  end

  // Entry storage: each slot takes lane 0 or lane 1 data on allocate or merge
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] r_pc;
      logic        r_taken;
      logic [31:0] r_target;
      logic        w_wr0;
      logic        w_wr1;

      assign w_wr0 = ~flush & ((w_alloc0 & (r_tail == PTR_W'(gi))) |
                               (w_merge0 & (w_newest_idx == PTR_W'(gi))));
      assign w_wr1 = ~flush & ((w_alloc1 & (w_slot1 == PTR_W'(gi))) |
                               (w_merge1 & (w_merge1_idx == PTR_W'(gi))));

      // Slot write; lane 1 is younger so it wins a (theoretical) collision
      always_ff @(posedge clk) begin
        if (w_wr1) begin
          r_pc     <= in_pc[1];
          r_taken  <= in_taken[1];
          r_target <= in_target[1];
        end else if (w_wr0) begin
          r_pc     <= in_pc[0];
          r_taken  <= in_taken[0];
          r_target <= in_target[0];
        end
      end

      assign w_pc_arr[gi]     = r_pc;
      assign w_taken_arr[gi]  = r_taken;
      assign w_target_arr[gi] = r_target;
    end
  endgenerate

  assign wen           = w_wen;
  assign pc_commit     = w_pc_arr[r_head];
  assign taken_commit  = w_taken_arr[r_head];
  assign target_commit = w_target_arr[r_head];
  assign count         = r_count;
  assign drop_cnt      = r_drop;

endmodule

// File: tb/tb_bpb_update_queue.sv
// Bench for bpb_update_queue: a queue-of-structs model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_bpb_update_queue;

  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_pc;
  logic [1:0]       in_taken;
  logic [1:0][31:0] in_target;
  logic             out_stall;
  logic             wen;
  logic [31:0]      pc_commit;
  logic             taken_commit;
  logic [31:0]      target_commit;
  logic [3:0]       count;
  logic [15:0]      drop_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t mq[$];
  int   mdrop = 0;

  bpb_update_queue #(.DEPTH(DEPTH), .DROP_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_taken(in_taken),
    .in_target(in_target), .out_stall(out_stall),
    .wen(wen), .pc_commit(pc_commit), .taken_commit(taken_commit),
    .target_commit(target_commit), .count(count), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one lane to the model: merge into the newest entry, else append, else drop.
  task automatic offer(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input bit blocked, inout int free, output bit dropped);
    ent_t e;
    dropped = 1'b0;
    if (mq.size() != 0 && mq[mq.size()-1].pc == pc) begin
      e = mq[mq.size()-1];
      e.taken  = tk;
      e.target = tg;
      mq[mq.size()-1] = e;
    end else if (!blocked && free > 0) begin
      e.pc = pc; e.taken = tk; e.target = tg;
      mq.push_back(e);
      free--;
    end else begin
      dropped = 1'b1;
      if (mdrop != 65535) mdrop++;
    end
  endtask

  task automatic model_update();
    int orig;
    int free;
    bit v0;
    bit d0;
    bit d1;
    if (reset) begin
      mq.delete();
      mdrop = 0;
      return;
    end
    if (flush) begin
      mq.delete();
      return;
    end
    orig = mq.size();
    if (orig != 0 && !out_stall) void'(mq.pop_front());
    free = DEPTH - orig;
    v0 = in_valid[0] && !(in_valid[1] && in_pc[0] == in_pc[1]);
    d0 = 1'b0;
    if (v0) offer(in_pc[0], in_taken[0], in_target[0], 1'b0, free, d0);
    if (in_valid[1]) offer(in_pc[1], in_taken[1], in_target[1], d0, free, d1);
  endtask

  task automatic edge1();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic t0,
                       input logic [31:0] g0, input logic [31:0] p1, input logic t1,
                       input logic [31:0] g1, input logic st, input logic fl);
    in_valid = v;
    in_pc[0] = p0; in_taken[0] = t0; in_target[0] = g0;
    in_pc[1] = p1; in_taken[1] = t1; in_target[1] = g1;
    out_stall = st;
    flush = fl;
    #1;
  endtask

  task automatic idle(input logic st);
    drive(2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, st, 1'b0);
  endtask

  task automatic push1(input logic [31:0] p, input logic t, input logic [31:0] g, input logic st);
    drive(2'b01, p, t, g, 32'h0, 1'b0, 32'h0, st, 1'b0);
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    logic exp_wen;
    if (!reset) begin
      exp_wen = (mq.size() != 0) && !out_stall;
      cmp("wen", 32'(wen), 32'(exp_wen));
      cmp("count", 32'(count), 32'(mq.size()));
      cmp("drop_cnt", 32'(drop_cnt), 32'(mdrop));
      if (exp_wen && wen) begin
        cmp("pc_commit", pc_commit, mq[0].pc);
        cmp("taken_commit", 32'(taken_commit), 32'(mq[0].taken));
        cmp("target_commit", target_commit, mq[0].target);
        $display("update pc=%08h taken=%0d target=%08h count=%0d",
                 pc_commit, taken_commit, target_commit, count);
      end
    end
  end

  initial begin
    reset = 1'b0;
    idle(1'b0);
    reset = 1'b1;
    edge1();
    edge1();
    cmp("rst_count", 32'(count), 32'd0);
    cmp("rst_wen", 32'(wen), 32'd0);
    cmp("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    edge1();

    // 1: single push appears the next cycle, then drains
    push1(32'h1000, 1'b1, 32'h2000, 1'b0);
    cmp("t1_wen_same_cycle", 32'(wen), 32'd0);
    edge1();
    idle(1'b0);
    cmp("t1_wen", 32'(wen), 32'd1);
    cmp("t1_pc", pc_commit, 32'h1000);
    cmp("t1_taken", 32'(taken_commit), 32'd1);
    cmp("t1_target", target_commit, 32'h2000);
    edge1();
    idle(1'b0);
    cmp("t1_wen_after", 32'(wen), 32'd0);
    cmp("t1_count_after", 32'(count), 32'd0);

    // 2: dual push drains in lane order
    drive(2'b11, 32'h100, 1'b1, 32'h200, 32'h104, 1'b0, 32'h108, 1'b0, 1'b0);
    edge1();
    idle(1'b0);
    cmp("t2_count2", 32'(count), 32'd2);
    cmp("t2_pc0", pc_commit, 32'h100);
    edge1();
    idle(1'b0);
    cmp("t2_count1", 32'(count), 32'd1);
    cmp("t2_pc1", pc_commit, 32'h104);
    cmp("t2_taken1", 32'(taken_commit), 32'd0);
    edge1();
    idle(1'b0);
    cmp("t2_count0", 32'(count), 32'd0);

    // 3: stalled fill with overflow, then drain in order
    for (int i = 0; i < 10; i++) begin
      push1(32'h500 + 32'(4 * i), 1'b0, 32'h5000 + 32'(i), 1'b1);
      edge1();
    end
    idle(1'b1);
    cmp("t3_count_full", 32'(count), 32'd8);
    cmp("t3_drop", 32'(drop_cnt), 32'd2);
    cmp("t3_wen_stalled", 32'(wen), 32'd0);
    for (int i = 0; i < 8; i++) begin
      idle(1'b0);
      cmp("t3_drain_pc", pc_commit, 32'h500 + 32'(4 * i));
      edge1();
    end
    idle(1'b0);
    cmp("t3_wen_empty", 32'(wen), 32'd0);

    // 4: tail merge while stalled, and intra-cycle dedup
    push1(32'h300, 1'b1, 32'h310, 1'b1);
    edge1();
    push1(32'h300, 1'b0, 32'h320, 1'b1);
    edge1();
    idle(1'b1);
    cmp("t4_merge_count", 32'(count), 32'd1);
    idle(1'b0);
    cmp("t4_merge_taken", 32'(taken_commit), 32'd0);
    cmp("t4_merge_target", target_commit, 32'h320);
    edge1();
    drive(2'b11, 32'h400, 1'b1, 32'h410, 32'h400, 1'b0, 32'h420, 1'b0, 1'b0);
    edge1();
    idle(1'b1);
    cmp("t4_dedup_count", 32'(count), 32'd1);
    idle(1'b0);
    cmp("t4_dedup_taken", 32'(taken_commit), 32'd0);
    cmp("t4_dedup_target", target_commit, 32'h420);
    edge1();

    // 5: flush with a dual push in the same cycle
    for (int i = 0; i < 5; i++) begin
      push1(32'h600 + 32'(4 * i), 1'b1, 32'h6000, 1'b1);
      edge1();
    end
    drive(2'b11, 32'h680, 1'b1, 32'h690, 32'h684, 1'b0, 32'h694, 1'b0, 1'b1);
    cmp("t5_wen_during_flush", 32'(wen), 32'd1);
    edge1();
    idle(1'b0);
    cmp("t5_count", 32'(count), 32'd0);
    cmp("t5_wen", 32'(wen), 32'd0);
    cmp("t5_drop", 32'(drop_cnt), 32'd2);

    // 6: full with pop active drops both lanes; then saturate the drop counter
    for (int i = 0; i < 8; i++) begin
      push1(32'h700 + 32'(4 * i), 1'b1, 32'h7000, 1'b1);
      edge1();
    end
    drive(2'b11, 32'h800, 1'b1, 32'h810, 32'h804, 1'b0, 32'h814, 1'b0, 1'b0);
    edge1();
    idle(1'b1);
    cmp("t6_count", 32'(count), 32'd7);
    cmp("t6_drop", 32'(drop_cnt), 32'd4);
    push1(32'h900, 1'b1, 32'h910, 1'b1);
    edge1();
    for (int i = 0; i < 32770; i++) begin
      drive(2'b11, 32'hA00, 1'b1, 32'hA10, 32'hA04, 1'b0, 32'hA14, 1'b1, 1'b0);
      edge1();
    end
    idle(1'b1);
    cmp("t6_drop_sat", 32'(drop_cnt), 32'hFFFF);
    cmp("t6_count_full", 32'(count), 32'd8);

    // Reset mid-operation clears state and drops wen immediately
    idle(1'b0);
    cmp("rst_mid_wen_before", 32'(wen), 32'd1);
    cmp("rst_mid_head", pc_commit, 32'h704);
    reset = 1'b1;
    #1;
    cmp("rst_mid_wen", 32'(wen), 32'd0);
    cmp("rst_mid_count", 32'(count), 32'd0);
    cmp("rst_mid_drop", 32'(drop_cnt), 32'd0);
    mq.delete();
    mdrop = 0;
    edge1();
    reset = 1'b0;
    idle(1'b0);
    edge1();
    cmp("rst_mid_after", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
